uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 70 +++++++
 tb/tb_uart_rx_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: first-word fall-through FIFO that captures UART receiver frames, with sticky error flags and a registered interrupt
module uart_rx_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data_valid,
  input  logic [WIDTH-1:0]     i_parallel_data,
  input  logic                 i_parity_error,
  input  logic                 i_stop_error,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  input  logic [CNT_WIDTH-1:0] i_threshold,
  output logic [WIDTH-1:0]     o_rd_data,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overrun,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_irq
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             valid_q, strobe, pop, wr;
  assign o_empty   = o_count == '0;
  assign o_full    = o_count == CNT_WIDTH'(DEPTH);
  assign strobe    = i_data_valid & ~valid_q;
  assign pop       = i_rd_en & ~o_empty;
  assign wr        = strobe & (~o_full | pop);
  assign o_rd_data = mem[rd_ptr];
  // storage is not reset; only entries between the pointers are ever observed
  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= i_parallel_data;
  end
  // valid edge register, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      valid_q <= i_data_valid;
      wr_ptr  <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      o_count <= o_count + CNT_WIDTH'(wr) - CNT_WIDTH'(pop);
    end
  end
  // sticky error flags: a set event in the same cycle beats a clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overrun    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_overrun    <= (strobe & o_full & ~pop) | (o_overrun & ~i_clr_err);
      o_parity_err <= i_parity_error | (o_parity_err & ~i_clr_err);
      o_frame_err  <= i_stop_error | (o_frame_err & ~i_clr_err);
    end
  end
  // interrupt registered from the already-updated count and flags, so it trails them by one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_irq <= 1'b0;
    else o_irq <= ((i_threshold != '0) && (o_count >= i_threshold)) | o_overrun | o_parity_err | o_frame_err;
  end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed scenario tests for uart_rx_buffer with hand-computed expectations
module tb_uart_rx_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_valid;
  logic [7:0] parallel_data;
  logic       parity_error, stop_error, rd_en, clr_err;
  logic [4:0] threshold;
  logic [7:0] rd_data;
  logic       empty, full, overrun, parity_err, frame_err, irq;
  logic [4:0] count;
  int passed = 0;
  int total = 0;

  uart_rx_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(data_valid), .i_parallel_data(parallel_data),
    .i_parity_error(parity_error), .i_stop_error(stop_error), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .i_threshold(threshold), .o_rd_data(rd_data), .o_empty(empty), .o_full(full), .o_count(count),
    .o_overrun(overrun), .o_parity_err(parity_err), .o_frame_err(frame_err), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [7:0] d);
    parallel_data = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_status got empty=%b full=%b exp empty=1 full=0", empty, full); else passed++;
    total++; if ({overrun, parity_err, frame_err, irq} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {overrun, parity_err, frame_err, irq}); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_long_pulse();
    parallel_data = 8'hA5;
    data_valid = 1'b1;
    repeat (5) tick();
    data_valid = 1'b0;
    tick();
    total++; if (count !== 5'd1) $display("FAIL long_pulse_count got %0d exp 1", count); else passed++;
    total++; if (rd_data !== 8'hA5) $display("FAIL long_pulse_data got %h exp a5", rd_data); else passed++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL long_pulse_drain got empty=%b exp 1", empty); else passed++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (count !== 5'd0) $display("FAIL pop_when_empty got count=%0d exp 0", count); else passed++;
  endtask

  task automatic test_overrun();
    int errs = 0;
    for (int i = 0; i < 17; i++) write_frame(8'(i));
    total++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL overrun_full got full=%b count=%0d exp full=1 count=16", full, count); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_flag got %b exp 1", overrun); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL overrun_irq got %b exp 1", irq); else passed++;
    for (int i = 0; i < 16; i++) begin
      if (rd_data !== 8'(i)) begin
        errs++;
        $display("FAIL overrun_read_%0d got %h exp %h", i, rd_data, 8'(i));
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    total++; if (errs != 0) $display("FAIL overrun_order got %0d bad reads exp 0", errs); else passed++;
    total++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL overrun_drain got empty=%b count=%0d exp empty=1 count=0", empty, count); else passed++;
    clear_errors();
    total++; if ({overrun, irq} !== 2'b00) $display("FAIL overrun_clear got %b exp 00", {overrun, irq}); else passed++;
  endtask

  task automatic test_full_write_pop();
    logic [7:0] last;
    for (int i = 0; i < 16; i++) write_frame(8'h20 + 8'(i));
    parallel_data = 8'h55;
    data_valid = 1'b1;
    rd_en = 1'b1;
    tick();
    data_valid = 1'b0;
    rd_en = 1'b0;
    tick();
    total++; if (overrun !== 1'b0) $display("FAIL full_pop_overrun got %b exp 0", overrun); else passed++;
    total++; if (count !== 5'd16) $display("FAIL full_pop_count got %0d exp 16", count); else passed++;
    total++; if (rd_data !== 8'h21) $display("FAIL full_pop_head got %h exp 21", rd_data); else passed++;
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rd_data;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    total++; if (last !== 8'h55) $display("FAIL full_pop_last got %h exp 55", last); else passed++;
  endtask

  task automatic test_threshold();
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) write_frame(8'h40 + 8'(i));
    total++; if (irq !== 1'b0) $display("FAIL thr_below got irq=%b exp 0", irq); else passed++;
    parallel_data = 8'h43;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    total++; if (count !== 5'd4 || irq !== 1'b0) $display("FAIL thr_reach got count=%0d irq=%b exp count=4 irq=0", count, irq); else passed++;
    tick();
    total++; if (irq !== 1'b1) $display("FAIL thr_rise got %b exp 1", irq); else passed++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (count !== 5'd3 || irq !== 1'b1) $display("FAIL thr_pop got count=%0d irq=%b exp count=3 irq=1", count, irq); else passed++;
    tick();
    total++; if (irq !== 1'b0) $display("FAIL thr_fall got %b exp 0", irq); else passed++;
    threshold = 5'd0;
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL thr_drain got empty=%b exp 1", empty); else passed++;
  endtask

  task automatic test_errors();
    stop_error = 1'b1;
    tick();
    stop_error = 1'b0;
    total++; if (frame_err !== 1'b1) $display("FAIL frame_set got %b exp 1", frame_err); else passed++;
    parity_error = 1'b1;
    clr_err = 1'b1;
    tick();
    parity_error = 1'b0;
    clr_err = 1'b0;
    total++; if ({frame_err, parity_err} !== 2'b01) $display("FAIL clr_priority got frame=%b parity=%b exp frame=0 parity=1", frame_err, parity_err); else passed++;
    tick();
    total++; if (irq !== 1'b1) $display("FAIL err_irq got %b exp 1", irq); else passed++;
    parity_error = 1'b1;
    write_frame(8'h99);
    parity_error = 1'b0;
    total++; if (count !== 5'd1 || rd_data !== 8'h99) $display("FAIL err_frame_stored got count=%0d data=%h exp count=1 data=99", count, rd_data); else passed++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    clear_errors();
    total++; if ({overrun, parity_err, frame_err, irq} !== 4'b0) $display("FAIL err_clear got %b exp 0000", {overrun, parity_err, frame_err, irq}); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) write_frame(8'h60 + 8'(i));
    parity_error = 1'b1;
    tick();
    parity_error = 1'b0;
    tick();
    total++; if (count !== 5'd7 || irq !== 1'b1) $display("FAIL pre_reset got count=%0d irq=%b exp count=7 irq=1", count, irq); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL async_reset_count got count=%0d empty=%b exp count=0 empty=1", count, empty); else passed++;
    total++; if ({overrun, parity_err, frame_err, irq} !== 4'b0) $display("FAIL async_reset_flags got %b exp 0000", {overrun, parity_err, frame_err, irq}); else passed++;
    parallel_data = 8'h77;
    data_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total++; if (count !== 5'd1 || rd_data !== 8'h77) $display("FAIL release_valid got count=%0d data=%h exp count=1 data=77", count, rd_data); else passed++;
    data_valid = 1'b0;
    tick();
  endtask

  initial begin
    data_valid = 1'b0;
    parallel_data = 8'h00;
    parity_error = 1'b0;
    stop_error = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    threshold = 5'd0;
    test_reset();
    test_long_pulse();
    test_overrun();
    test_full_write_pop();
    test_threshold();
    test_errors();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
